// File: rtl/dac_daisy_receiver.sv
// dac_daisy_receiver: oversampled DAC daisy-chain responder with show-ahead word FIFO and frame status
module dac_daisy_receiver #(
  parameter int WORD_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dac_sck,
  input  logic                          dac_cs_b,
  input  logic                          dac_sdi,
  output logic [WORD_WIDTH-1:0]         word_dout,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_done,
  output logic [7:0]                    frame_words,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WORD_WIDTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, sdi_sync_q, fill_q;
  logic s_sck, s_cs_b, s_sdi, s_sck_d_q, s_cs_b_d_q, armed_q, armed_d;
  logic sck_rise, cs_fall, cs_rise;
  logic [1:0] state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d, push_word;
  logic [7:0] wcnt_q, wcnt_d, frame_words_q, frame_words_d;
  logic frame_done_q, frame_done_d, frame_err_q, frame_err_d, overflow_q, overflow_d, push;
  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic full, wr_en, rd_en;
  assign s_sck  = sck_sync_q[SYNC_STAGES-1];
  assign s_cs_b = cs_sync_q[SYNC_STAGES-1];
  assign s_sdi  = sdi_sync_q[SYNC_STAGES-1];
  // cs_b is only trusted once a real high level has crossed the synchroniser, so a frame caught mid-flight by reset is ignored
  assign armed_d  = armed_q | (fill_q[SYNC_STAGES-1] & s_cs_b);
  assign sck_rise = s_sck & ~s_sck_d_q;
  assign cs_fall  = armed_q & ~s_cs_b & s_cs_b_d_q;
  assign cs_rise  = s_cs_b & ~s_cs_b_d_q;
  assign push_word = {shift_q[WORD_WIDTH-2:0], s_sdi};
  always_comb begin
    state_d       = state_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    wcnt_d        = wcnt_q;
    frame_words_d = frame_words_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    push          = 1'b0;
    if (state_q == IDLE) begin
      bit_d   = '0;
      shift_d = '0;
      wcnt_d  = '0;
      state_d = cs_fall ? SHIFT : IDLE;
    end else if (state_q == SHIFT) begin
      if (cs_rise) begin
        state_d       = IDLE;
        frame_done_d  = bit_q == '0;
        frame_err_d   = bit_q != '0;
        frame_words_d = bit_q == '0 ? wcnt_q : frame_words_q;
      end else if (sck_rise && !s_cs_b) begin
        shift_d = push_word;
        push    = bit_q == BW'(WORD_WIDTH - 1);
        bit_d   = push ? '0 : bit_q + BW'(1);
        wcnt_d  = push && wcnt_q != 8'hFF ? wcnt_q + 8'd1 : wcnt_q;
      end
    end else begin
      state_d = IDLE;
    end
  end
  assign full       = count_q == CW'(FIFO_DEPTH);
  assign rd_en      = word_ready && count_q != '0;
  assign wr_en      = push && (!full || rd_en);
  assign count_d    = count_q + CW'(wr_en) - CW'(rd_en);
  assign overflow_d = (push && full && !rd_en) || (overflow_q && !err_clr);
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q    <= '0;
      cs_sync_q     <= '1;
      sdi_sync_q    <= '0;
      fill_q        <= '0;
      s_sck_d_q     <= 1'b0;
      s_cs_b_d_q    <= 1'b1;
      armed_q       <= 1'b0;
      state_q       <= IDLE;
      bit_q         <= '0;
      shift_q       <= '0;
      wcnt_q        <= '0;
      frame_words_q <= '0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], dac_sck};
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], dac_cs_b};
      sdi_sync_q    <= {sdi_sync_q[SYNC_STAGES-2:0], dac_sdi};
      fill_q        <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      s_sck_d_q     <= s_sck;
      s_cs_b_d_q    <= s_cs_b;
      armed_q       <= armed_d;
      state_q       <= state_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      wcnt_q        <= wcnt_d;
      frame_words_q <= frame_words_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
      if (wr_en) mem_q[wr_ptr_q] <= push_word;
      wr_ptr_q      <= wr_ptr_q + AW'(wr_en);
      rd_ptr_q      <= rd_ptr_q + AW'(rd_en);
      count_q       <= count_d;
    end
  end
  assign word_dout   = mem_q[rd_ptr_q];
  assign word_valid  = count_q != '0;
  assign fifo_count  = count_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign frame_words = frame_words_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_dac_daisy_receiver.sv
// tb_dac_daisy_receiver: directed checks of the DAC daisy-chain responder
module tb_dac_daisy_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dac_sck = 1'b0;
  logic dac_cs_b = 1'b1;
  logic dac_sdi = 1'b0;
  logic word_ready = 1'b0;
  logic err_clr = 1'b0;
  logic [31:0] word_dout;
  logic word_valid, frame_done, frame_err, overflow;
  logic [2:0] fifo_count;
  logic [7:0] frame_words;
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] pops[$];
  dac_daisy_receiver dut (
    .clk(clk), .rst(rst), .dac_sck(dac_sck), .dac_cs_b(dac_cs_b), .dac_sdi(dac_sdi),
    .word_dout(word_dout), .word_valid(word_valid), .word_ready(word_ready),
    .fifo_count(fifo_count), .frame_done(frame_done), .frame_words(frame_words),
    .frame_err(frame_err), .overflow(overflow), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (word_valid && word_ready) pops.push_back(word_dout);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    @(posedge clk); #2;
    dac_sdi = b;
    dac_sck = 1'b0;
    repeat (2) @(posedge clk);
    #2 dac_sck = 1'b1;
    @(posedge clk);
  endtask
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
  endtask
  task automatic start_frame();
    @(posedge clk); #2 dac_cs_b = 1'b0;
    repeat (4) @(posedge clk);
  endtask
  task automatic end_frame();
    repeat (3) @(posedge clk);
    #2;
    dac_cs_b = 1'b1;
    dac_sck = 1'b0;
    repeat (10) @(posedge clk);
  endtask
  task automatic set_ready(input logic v);
    @(posedge clk); #1 word_ready = v;
  endtask
  task automatic drain();
    set_ready(1'b1);
    repeat (8) @(posedge clk);
    set_ready(1'b0);
    repeat (2) @(posedge clk);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", word_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_dout", word_dout, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_words", frame_words, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    // single word, consumer always ready
    set_ready(1'b1);
    start_frame();
    send_bits(32'hA5C3_0F81, 32);
    end_frame();
    check("t1_npops", pops.size(), 1);
    if (pops.size() > 0) check("t1_word", pops[0], 32'hA5C3_0F81);
    check("t1_done", done_cnt, 1);
    check("t1_err", err_cnt, 0);
    check("t1_words", frame_words, 1);
    check("t1_count", fifo_count, 0);
    // three-word daisy frame held in the FIFO
    set_ready(1'b0);
    pops.delete();
    start_frame();
    send_bits(32'h0000_0001, 32);
    send_bits(32'h8000_0000, 32);
    send_bits(32'hFFFF_FFFF, 32);
    end_frame();
    check("t2_count", fifo_count, 3);
    check("t2_words", frame_words, 3);
    check("t2_done", done_cnt, 2);
    check("t2_head", word_dout, 32'h0000_0001);
    drain();
    check("t2_npops", pops.size(), 3);
    if (pops.size() == 3) begin
      check("t2_pop0", pops[0], 32'h0000_0001);
      check("t2_pop1", pops[1], 32'h8000_0000);
      check("t2_pop2", pops[2], 32'hFFFF_FFFF);
    end
    // partial word then a clean frame
    pops.delete();
    start_frame();
    send_bits(32'hFFFF_F000, 20);
    end_frame();
    check("t3_err", err_cnt, 1);
    check("t3_done", done_cnt, 2);
    check("t3_count", fifo_count, 0);
    check("t3_words", frame_words, 3);
    start_frame();
    send_bits(32'h1234_5678, 32);
    end_frame();
    check("t3b_count", fifo_count, 1);
    check("t3b_head", word_dout, 32'h1234_5678);
    check("t3b_words", frame_words, 1);
    check("t3b_done", done_cnt, 3);
    drain();
    check("t3b_npops", pops.size(), 1);
    // overflow: five words into four slots
    pops.delete();
    start_frame();
    for (int k = 1; k <= 5; k++) send_bits(32'(k), 32);
    end_frame();
    check("t4_count", fifo_count, 4);
    check("t4_ovf", overflow, 1);
    check("t4_head", word_dout, 32'd1);
    check("t4_words", frame_words, 5);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("t4_clr", overflow, 0);
    // push while full, with a pop landing on the push cycle
    start_frame();
    send_bits(32'd6, 31);
    @(posedge clk); #2;
    dac_sdi = 1'b0;
    dac_sck = 1'b0;
    repeat (2) @(posedge clk);
    #2 dac_sck = 1'b1;
    repeat (2) @(posedge clk);
    #1 word_ready = 1'b1;
    @(posedge clk); #1 word_ready = 1'b0;
    check("t4_full_count", fifo_count, 4);
    check("t4_full_ovf", overflow, 0);
    check("t4_full_head", word_dout, 32'd2);
    end_frame();
    check("t4_done", done_cnt, 5);
    drain();
    check("t4_npops", pops.size(), 5);
    if (pops.size() == 5) begin
      check("t4_pop0", pops[0], 32'd1);
      check("t4_pop1", pops[1], 32'd2);
      check("t4_pop2", pops[2], 32'd3);
      check("t4_pop3", pops[3], 32'd4);
      check("t4_pop4", pops[4], 32'd6);
    end
    // gating: sck with cs_b high, then reset mid-frame
    send_bits(32'hCAFE_F00D, 32);
    repeat (4) @(posedge clk);
    check("t5_idle_count", fifo_count, 0);
    check("t5_idle_err", err_cnt, 1);
    start_frame();
    send_bits(32'hDEAD_BEEF, 10);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t5_rst_words", frame_words, 0);
    check("t5_rst_count", fifo_count, 0);
    check("t5_rst_dout", word_dout, 0);
    check("t5_rst_valid", word_valid, 0);
    send_bits(32'hEEFF_FFFF << 10, 22);
    end_frame();
    check("t5_after_count", fifo_count, 0);
    check("t5_after_done", done_cnt, 5);
    check("t5_after_err", err_cnt, 1);
    check("t5_after_words", frame_words, 0);
    start_frame();
    send_bits(32'hDEAD_BEEF, 32);
    end_frame();
    check("t5_new_count", fifo_count, 1);
    check("t5_new_head", word_dout, 32'hDEAD_BEEF);
    check("t5_new_words", frame_words, 1);
    drain();
    // zero-word frame
    start_frame();
    repeat (20) @(posedge clk);
    end_frame();
    check("t6_done", done_cnt, 7);
    check("t6_words", frame_words, 0);
    check("t6_err", err_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
